apb_reg_slave: RTL and testbench

APB completer that terminates the transfers issued by the team's APB master block. It holds a small register bank (one ID word, one transfer counter, six read/write words) at a fixed base address, inserts a programmable number of wait states via `pready_o`, and flags decode or permission faults with `pslverr_o`. It sits directly downstream of the master on the same clock domain.

---
 rtl/apb_reg_slave.sv | 126 ++++++++++++
 tb/tb_apb_reg_slave.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_reg_slave.sv
// APB completer with an ID word, a transfer counter and six read/write words.
// Programmable wait states; pslverr_o flags address misses and writes to read-only words.
module apb_reg_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'hDEAD_C000,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] ID_VALUE    = 32'hA9B0_0016
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        psel_i,
    input  logic        penable_i,
    input  logic [31:0] paddr_i,
    input  logic        pwrite_i,
    input  logic [31:0] pwdata_i,
    output logic        pready_o,
    output logic [31:0] prdata_o,
    output logic        pslverr_o
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t      state, state_next;
    logic [3:0]  wait_cnt;
    logic        cap_hit;
    logic [2:0]  cap_idx;
    logic        cap_write;
    logic [31:0] cap_wdata;
    logic [31:0] xfer_cnt;
    logic [31:0] rw_regs [6];

    logic        setup;
    logic        ready;
    logic        err;
    logic [2:0]  rw_idx;
    logic [31:0] rd_value;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{paddr_i[11:5], paddr_i[1:0]};

    assign setup  = (state == IDLE) && psel_i && !penable_i;
    assign ready  = (state == ACCESS) && psel_i && penable_i && (wait_cnt == 4'd0);
    assign err    = !cap_hit || (cap_write && (cap_idx < 3'd2));
    assign rw_idx = 3'(cap_idx - 3'd2);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (setup) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (!psel_i || ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Address decode is reduced to hit/index at setup so later bus changes cannot leak in.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt  <= '0;
            cap_hit   <= 1'b0;
            cap_idx   <= '0;
            cap_write <= 1'b0;
            cap_wdata <= '0;
            xfer_cnt  <= '0;
            for (int unsigned i = 0; i < 6; i++) begin
                rw_regs[i] <= '0;
            end
        end else begin
            if (setup) begin
                wait_cnt  <= 4'(WAIT_CYCLES);
                cap_hit   <= (paddr_i[31:12] == BASE_ADDR[31:12]);
                cap_idx   <= paddr_i[4:2];
                cap_write <= pwrite_i;
                cap_wdata <= pwdata_i;
            end else if ((state == ACCESS) && psel_i && penable_i && (wait_cnt != 4'd0)) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (ready) begin
                xfer_cnt <= xfer_cnt + 32'd1;
                if (cap_write && !err) begin
                    rw_regs[rw_idx] <= cap_wdata;
                end
            end
        end
    end

    always_comb begin
        rd_value = '0;
        case (cap_idx)
            3'd0:    rd_value = ID_VALUE;
            3'd1:    rd_value = xfer_cnt;
            default: rd_value = rw_regs[rw_idx];
        endcase
    end

    always_comb begin
        pready_o  = 1'b0;
        pslverr_o = 1'b0;
        prdata_o  = '0;
        if (ready) begin
            pready_o  = 1'b1;
            pslverr_o = err;
            if (!err && !cap_write) begin
                prdata_o = rd_value;
            end
        end
    end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed bench for apb_reg_slave: register access, wait states, errors, abort and reset.
module tb_apb_reg_slave;

    localparam int unsigned WAIT = 2;

    logic        clk;
    logic        reset;
    logic        psel_i;
    logic        penable_i;
    logic [31:0] paddr_i;
    logic        pwrite_i;
    logic [31:0] pwdata_i;
    logic        pready_o;
    logic [31:0] prdata_o;
    logic        pslverr_o;

    int unsigned n_pass;
    int unsigned n_total;

    apb_reg_slave #(
        .BASE_ADDR   (32'hDEAD_C000),
        .WAIT_CYCLES (WAIT),
        .ID_VALUE    (32'hA9B0_0016)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .psel_i    (psel_i),
        .penable_i (penable_i),
        .paddr_i   (paddr_i),
        .pwrite_i  (pwrite_i),
        .pwdata_i  (pwdata_i),
        .pready_o  (pready_o),
        .prdata_o  (prdata_o),
        .pslverr_o (pslverr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one transfer from setup to ready, scrambling the bus after setup.
    task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic serr, output int unsigned cyc);
        rdata = '0;
        serr  = 1'b0;
        cyc   = 0;
        psel_i    = 1'b1;
        penable_i = 1'b0;
        paddr_i   = addr;
        pwrite_i  = wr;
        pwdata_i  = wdata;
        @(negedge clk);
        check("setup_ready_low", 32'(pready_o), 32'd0);
        @(posedge clk); #1;
        penable_i = 1'b1;
        paddr_i   = ~addr;
        pwrite_i  = ~wr;
        pwdata_i  = ~wdata;
        for (int unsigned k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (pready_o) begin
                cyc   = k;
                rdata = prdata_o;
                serr  = pslverr_o;
                break;
            end
            check("wait_prdata_zero", prdata_o, 32'd0);
            check("wait_pslverr_zero", 32'(pslverr_o), 32'd0);
            @(posedge clk); #1;
        end
        if (cyc == 0) begin
            check("ready_timeout", 32'd0, 32'd1);
        end else begin
            @(posedge clk); #1;
        end
        psel_i    = 1'b0;
        penable_i = 1'b0;
    endtask

    task automatic wr_chk(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input logic exp_err);
        logic [31:0] rd;
        logic        se;
        int unsigned c;
        xfer(addr, 1'b1, data, rd, se, c);
        check({tag, "_cycle"}, c, WAIT + 1);
        check({tag, "_err"}, 32'(se), 32'(exp_err));
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp_data,
                          input logic exp_err);
        logic [31:0] rd;
        logic        se;
        int unsigned c;
        xfer(addr, 1'b0, 32'h0, rd, se, c);
        check({tag, "_cycle"}, c, WAIT + 1);
        check({tag, "_err"}, 32'(se), 32'(exp_err));
        check({tag, "_data"}, rd, exp_data);
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        reset     = 1'b1;
        psel_i    = 1'b0;
        penable_i = 1'b0;
        paddr_i   = '0;
        pwrite_i  = 1'b0;
        pwdata_i  = '0;
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_pready", 32'(pready_o), 32'd0);
        check("rst_pslverr", 32'(pslverr_o), 32'd0);
        check("rst_prdata", prdata_o, 32'd0);
        @(posedge clk); #1;

        rd_chk("rst_cnt", 32'hDEAD_C004, 32'd0, 1'b0);
        rd_chk("id", 32'hDEAD_C000, 32'hA9B0_0016, 1'b0);
        wr_chk("wr2", 32'hDEAD_C008, 32'h0000_002B, 1'b0);
        rd_chk("rd2", 32'hDEAD_C008, 32'h0000_002B, 1'b0);
        rd_chk("cnt4", 32'hDEAD_C004, 32'd4, 1'b0);

        wr_chk("wr7_alias", 32'hDEAD_CAFE, 32'h1234_5678, 1'b0);
        rd_chk("rd7", 32'hDEAD_C01C, 32'h1234_5678, 1'b0);

        wr_chk("wr_id", 32'hDEAD_C000, 32'hFFFF_FFFF, 1'b1);
        rd_chk("id_kept", 32'hDEAD_C000, 32'hA9B0_0016, 1'b0);
        rd_chk("miss", 32'h1000_0008, 32'd0, 1'b1);
        rd_chk("cnt10", 32'hDEAD_C004, 32'd10, 1'b0);
        wr_chk("wr_cnt", 32'hDEAD_C004, 32'h5555_5555, 1'b1);
        rd_chk("cnt12", 32'hDEAD_C004, 32'd12, 1'b0);

        // Abort: psel dropped at T1+1 of a write to index 3
        psel_i    = 1'b1;
        penable_i = 1'b0;
        paddr_i   = 32'hDEAD_C00C;
        pwrite_i  = 1'b1;
        pwdata_i  = 32'hCAFE_0003;
        @(posedge clk); #1;
        penable_i = 1'b1;
        @(negedge clk);
        check("abort_t1_ready", 32'(pready_o), 32'd0);
        @(posedge clk); #1;
        psel_i    = 1'b0;
        penable_i = 1'b0;
        @(negedge clk);
        check("abort_t2_ready", 32'(pready_o), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("abort_t3_ready", 32'(pready_o), 32'd0);
        @(posedge clk); #1;
        rd_chk("abort_rd3", 32'hDEAD_C00C, 32'd0, 1'b0);
        rd_chk("abort_cnt", 32'hDEAD_C004, 32'd14, 1'b0);

        // Reset asserted at T1 of a write to index 4
        psel_i    = 1'b1;
        penable_i = 1'b0;
        paddr_i   = 32'hDEAD_C010;
        pwrite_i  = 1'b1;
        pwdata_i  = 32'h0000_0099;
        @(posedge clk); #1;
        penable_i = 1'b1;
        @(negedge clk);
        check("midrst_t1_ready", 32'(pready_o), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset     = 1'b0;
        psel_i    = 1'b0;
        penable_i = 1'b0;
        @(negedge clk);
        check("midrst_after_ready", 32'(pready_o), 32'd0);
        @(posedge clk); #1;
        rd_chk("midrst_rd4", 32'hDEAD_C010, 32'd0, 1'b0);
        rd_chk("midrst_rd2", 32'hDEAD_C008, 32'd0, 1'b0);
        rd_chk("midrst_rd7", 32'hDEAD_C01C, 32'd0, 1'b0);
        rd_chk("midrst_cnt", 32'hDEAD_C004, 32'd3, 1'b0);
        wr_chk("wr5", 32'hDEAD_C014, 32'h8000_0001, 1'b0);
        rd_chk("rd5", 32'hDEAD_C014, 32'h8000_0001, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
